// File: rtl/coffee_grade_classifier.sv
// Averages windows of 2^LOG2_N sensor samples and grades the average into a
// 2-bit estado code (00 baja, 01 media, 10 alta, 11 no result/fault) with hysteresis.
module coffee_grade_classifier #(
   parameter int W       = 8,
   parameter int LOG2_N  = 2,
   parameter int TH_LOW  = 80,
   parameter int TH_HIGH = 160,
   parameter int HYST    = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] sample,
   input  logic         sample_valid,
   output logic         sample_ready,
   output logic [1:0]   estado,
   output logic         estado_valid,
   output logic         fault
);

   localparam int AW = W + LOG2_N;
   localparam int CW = LOG2_N;
   localparam int XW = W + 1;
   localparam int N  = 1 << LOG2_N;

   localparam logic [1:0] G_BAJA  = 2'b00;
   localparam logic [1:0] G_MEDIA = 2'b01;
   localparam logic [1:0] G_ALTA  = 2'b10;
   localparam logic [1:0] G_NONE  = 2'b11;

   localparam logic [XW-1:0] T_LO    = XW'(TH_LOW);
   localparam logic [XW-1:0] T_HI    = XW'(TH_HIGH);
   localparam logic [XW-1:0] T_LO_UP = XW'(TH_LOW + HYST);
   localparam logic [XW-1:0] T_LO_DN = XW'(TH_LOW - HYST);
   localparam logic [XW-1:0] T_HI_UP = XW'(TH_HIGH + HYST);
   localparam logic [XW-1:0] T_HI_DN = XW'(TH_HIGH - HYST);

   if (LOG2_N < 1) begin : g_bad_log2n
      $error("LOG2_N must be at least 1");
   end
   if (HYST > TH_LOW) begin : g_bad_hyst
      $error("HYST must not exceed TH_LOW");
   end
   if (TH_LOW + HYST >= TH_HIGH - HYST) begin : g_bad_band
      $error("TH_LOW+HYST must be below TH_HIGH-HYST");
   end
   if (TH_HIGH + HYST > (1 << W) - 1) begin : g_bad_top
      $error("TH_HIGH+HYST must fit in W bits");
   end

   typedef enum logic {ACC, EVAL} state_t;

   state_t          state_q,  state_d;
   logic [CW-1:0]   cnt_q,    cnt_d;
   logic [AW-1:0]   acc_q,    acc_d;
   logic            wfault_q, wfault_d;
   logic [1:0]      prev_q,   prev_d;
   logic            pend_q,   pend_d;
   logic [1:0]      pend_est_q, pend_est_d;
   logic            pend_flt_q, pend_flt_d;
   logic [1:0]      estado_q, estado_d;
   logic            estado_valid_q, estado_valid_d;
   logic            fault_q,  fault_d;

   logic [W-1:0]    avg;
   logic [XW-1:0]   avg_x;
   logic [1:0]      grade;

   assign avg   = acc_q[AW-1:LOG2_N];
   assign avg_x = {1'b0, avg};

   // Moves across a threshold need the hysteresis margin; multi-step jumps
   // fall back to the nearer class when the outer margin is not met.
   always_comb begin
      grade = G_NONE;
      unique case (prev_q)
         G_BAJA: begin
            if (avg_x >= T_HI_UP)      grade = G_ALTA;
            else if (avg_x >= T_LO_UP) grade = G_MEDIA;
            else                       grade = G_BAJA;
         end
         G_MEDIA: begin
            if (avg_x >= T_HI_UP)      grade = G_ALTA;
            else if (avg_x < T_LO_DN)  grade = G_BAJA;
            else                       grade = G_MEDIA;
         end
         G_ALTA: begin
            if (avg_x < T_LO_DN)       grade = G_BAJA;
            else if (avg_x < T_HI_DN)  grade = G_MEDIA;
            else                       grade = G_ALTA;
         end
         default: begin
            if (avg_x < T_LO)          grade = G_BAJA;
            else if (avg_x >= T_HI)    grade = G_ALTA;
            else                       grade = G_MEDIA;
         end
      endcase
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      acc_d          = acc_q;
      wfault_d       = wfault_q;
      prev_d         = prev_q;
      pend_d         = 1'b0;
      pend_est_d     = pend_est_q;
      pend_flt_d     = pend_flt_q;
      estado_d       = estado_q;
      estado_valid_d = 1'b0;
      fault_d        = fault_q;

      unique case (state_q)
         ACC: begin
            if (sample_valid) begin
               acc_d = acc_q + AW'(sample);
               cnt_d = cnt_q + CW'(1);
               if (sample == '1) wfault_d = 1'b1;
               if (cnt_q == CW'(N - 1)) state_d = EVAL;
            end
         end
         EVAL: begin
            pend_d     = 1'b1;
            pend_est_d = wfault_q ? G_NONE : grade;
            pend_flt_d = wfault_q;
            prev_d     = wfault_q ? G_NONE : grade;
            acc_d      = '0;
            cnt_d      = '0;
            wfault_d   = 1'b0;
            state_d    = ACC;
         end
         default: state_d = ACC;
      endcase

      // Result is published one edge after EVAL so estado lands on the
      // second edge after the window's last accept.
      if (pend_q) begin
         estado_d       = pend_est_q;
         fault_d        = pend_flt_q;
         estado_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= ACC;
         cnt_q          <= '0;
         acc_q          <= '0;
         wfault_q       <= 1'b0;
         prev_q         <= G_NONE;
         pend_q         <= 1'b0;
         pend_est_q     <= G_NONE;
         pend_flt_q     <= 1'b0;
         estado_q       <= G_NONE;
         estado_valid_q <= 1'b0;
         fault_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         acc_q          <= acc_d;
         wfault_q       <= wfault_d;
         prev_q         <= prev_d;
         pend_q         <= pend_d;
         pend_est_q     <= pend_est_d;
         pend_flt_q     <= pend_flt_d;
         estado_q       <= estado_d;
         estado_valid_q <= estado_valid_d;
         fault_q        <= fault_d;
      end
   end

   assign sample_ready = (state_q == ACC);
   assign estado       = estado_q;
   assign estado_valid = estado_valid_q;
   assign fault        = fault_q;

endmodule

// File: tb/tb_coffee_grade_classifier.sv
// Scoreboard bench for coffee_grade_classifier: directed windows push expected
// grade/fault/cycle; a monitor pops and compares on every estado_valid pulse.
module tb_coffee_grade_classifier;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] sample = '0;
   logic       sample_valid = 1'b0;
   logic       sample_ready;
   logic [1:0] estado;
   logic       estado_valid;
   logic       fault;

   coffee_grade_classifier #(
      .W(8), .LOG2_N(2), .TH_LOW(80), .TH_HIGH(160), .HYST(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .sample(sample),
      .sample_valid(sample_valid),
      .sample_ready(sample_ready),
      .estado(estado),
      .estado_valid(estado_valid),
      .fault(fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [1:0] est;
      logic       flt;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   int   last_acc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: compares every estado_valid pulse against the scoreboard head.
   always @(negedge clk) begin
      if (estado_valid) begin
         if (q.size() == 0) begin
            chk("spurious_valid", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("latency", cyc, e.cyc);
            chk("estado", int'(estado), int'(e.est));
            chk("fault", int'(fault), int'(e.flt));
         end
      end else if (q.size() > 0 && cyc > q[0].cyc) begin
         exp_t e;
         e = q.pop_front();
         chk("missing_valid", 0, 1);
      end
   end

   task automatic send(input logic [7:0] v, input int gap);
      int t;
      repeat (gap) begin
         @(negedge clk);
         sample_valid = 1'b0;
      end
      @(negedge clk);
      sample_valid = 1'b1;
      sample = v;
      t = 0;
      while (!sample_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!sample_ready) chk("ready_timeout", 0, 1);
      last_acc = cyc + 1;
   endtask

   task automatic window(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d,
                         input int gap, input logic [1:0] est, input logic flt);
      exp_t e;
      send(a, gap);
      send(b, gap);
      send(c, gap);
      send(d, gap);
      e.cyc = last_acc + 2;
      e.est = est;
      e.flt = flt;
      q.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         sample_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (q.size() > 0 && t < 30) begin
         @(negedge clk);
         t++;
      end
      if (q.size() > 0) chk("drain_timeout", int'(q.size()), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      // Reset and idle
      repeat (3) @(negedge clk);
      chk("rst_estado", int'(estado), 3);
      chk("rst_valid", int'(estado_valid), 0);
      chk("rst_fault", int'(fault), 0);
      reset = 1'b1;
      idle(5);
      chk("idle_ready", int'(sample_ready), 1);
      chk("idle_estado", int'(estado), 3);

      // Basic grades, back-to-back; ready drops for exactly the EVAL cycle
      window(8'd50, 8'd50, 8'd50, 8'd50, 0, 2'b00, 1'b0);
      @(negedge clk);
      sample_valid = 1'b0;
      chk("eval_ready_low", int'(sample_ready), 0);
      @(negedge clk);
      chk("acc_ready_high", int'(sample_ready), 1);
      window(8'd200, 8'd200, 8'd200, 8'd200, 0, 2'b10, 1'b0);
      window(8'd50, 8'd50, 8'd50, 8'd50, 0, 2'b00, 1'b0);

      // Hysteresis from 00
      window(8'd84, 8'd84, 8'd84, 8'd84, 0, 2'b00, 1'b0);
      window(8'd88, 8'd88, 8'd88, 8'd88, 0, 2'b01, 1'b0);
      window(8'd75, 8'd75, 8'd75, 8'd75, 0, 2'b01, 1'b0);
      window(8'd71, 8'd71, 8'd71, 8'd71, 0, 2'b00, 1'b0);

      // Truncation, each preceded by a fault window to return to 11
      window(8'd100, 8'd255, 8'd100, 8'd100, 0, 2'b11, 1'b1);
      window(8'd161, 8'd160, 8'd160, 8'd160, 0, 2'b10, 1'b0);
      window(8'd100, 8'd255, 8'd100, 8'd100, 0, 2'b11, 1'b1);
      window(8'd159, 8'd160, 8'd160, 8'd160, 0, 2'b01, 1'b0);

      // Fault then clean window
      window(8'd100, 8'd255, 8'd100, 8'd100, 0, 2'b11, 1'b1);
      window(8'd100, 8'd100, 8'd100, 8'd100, 0, 2'b01, 1'b0);

      // Saturated sample offered during EVAL must be ignored; gapped window
      @(negedge clk);
      sample_valid = 1'b1;
      sample = 8'd255;
      chk("eval_ignores", int'(sample_ready), 0);
      window(8'd170, 8'd180, 8'd170, 8'd180, 2, 2'b10, 1'b0);
      idle(1);
      drain();

      // Reset mid-window discards the partial sum
      send(8'd20, 0);
      send(8'd20, 1);
      @(negedge clk);
      sample_valid = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_estado", int'(estado), 3);
      chk("midrst_valid", int'(estado_valid), 0);
      chk("midrst_fault", int'(fault), 0);
      reset = 1'b1;
      window(8'd165, 8'd165, 8'd165, 8'd165, 1, 2'b10, 1'b0);
      idle(1);
      drain();
      idle(8);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
